// File: rtl/sensor_temp_clasificador.sv
// sensor_temp_clasificador
// Reads an 8-bit temperature from a serial ADC over a 3-wire link, validates
// the 16-bit frame and classifies the reading against a low-temperature
// threshold with hysteresis and N-sample confirmation. The result selects the
// mem_T_baja pattern (adress: 0 = normal, 1 = low temperature).
//
// Ports:
//   clk            system clock
//   reset_n        synchronous reset, active-low
//   habilitar      1 = run conversions continuously
//   miso           ADC serial data
//   cs_n           ADC chip select, active-low
//   sclk           ADC serial clock
//   adress         classification; 1 = low temperature
//   temp_valor     last valid temperature
//   muestra_lista  one-clk pulse per valid frame
//   error_trama    sticky malformed-frame flag
//
// state  | meaning
// IDLE   | cs_n high, waiting for habilitar
// SETUP  | cs_n low, sclk low for CLK_DIV clks before the first edge
// SHIFT  | 32 sclk half-periods, miso captured on each rising edge
// CIERRE | one clk, cs_n high, frame checked and classification updated
// ESPERA | GAP clks of idle, cs_n high
module sensor_temp_clasificador #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned GAP       = 50,
  parameter logic [7:0]  T_LOW     = 8'd20,
  parameter logic [7:0]  HYST      = 8'd3,
  parameter int unsigned N_CONFIRM = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       habilitar,
  input  logic       miso,
  output logic       cs_n,
  output logic       sclk,
  output logic       adress,
  output logic [7:0] temp_valor,
  output logic       muestra_lista,
  output logic       error_trama
);

  localparam int unsigned TMAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, CIERRE, ESPERA} state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic [5:0]    edges;
  logic [15:0]   frame;
  logic [3:0]    conf_cnt;

  logic          tc;
  logic          closing;
  logic          frame_ok;
  logic [7:0]    temp_new;
  logic [8:0]    exit_thr;
  logic          qualifies;

  assign tc       = (timer == '0);
  // Frame is complete once the 32nd half-period (16th falling edge) ends.
  assign closing  = (state == SHIFT) && (state_next == CIERRE);
  assign frame_ok = (frame[15:12] == 4'h0) && (frame[3:0] == 4'h0);
  assign temp_new = frame[11:4];
  // Exit threshold in 9 bits so T_LOW+HYST never wraps.
  assign exit_thr = {1'b0, T_LOW} + {1'b0, HYST};
  assign qualifies = adress ? ({1'b0, temp_new} >= exit_thr)
                            : (temp_new < T_LOW);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (habilitar) state_next = SETUP;
      SETUP:   if (tc) state_next = SHIFT;
      SHIFT:   if (tc && edges == 6'd31) state_next = CIERRE;
      CIERRE:  state_next = ESPERA;
      ESPERA:  if (tc) state_next = habilitar ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_n          <= 1'b1;
      sclk          <= 1'b0;
      adress        <= 1'b0;
      temp_valor    <= 8'd0;
      muestra_lista <= 1'b0;
      error_trama   <= 1'b0;
      timer         <= '0;
      edges         <= '0;
      frame         <= '0;
      conf_cnt      <= '0;
    end else begin
      muestra_lista <= 1'b0;
      // cs_n follows the state being entered so it is aligned with it.
      cs_n <= !((state_next == SETUP) || (state_next == SHIFT));

      // Down-counter reloaded on every state change and every sclk toggle.
      if (state != state_next)
        timer <= (state_next == ESPERA) ? TW'(GAP - 1) : TW'(CLK_DIV - 1);
      else if (!tc)
        timer <= timer - 1'b1;
      else if (state == SHIFT)
        timer <= TW'(CLK_DIV - 1);

      if (state == SETUP) begin
        sclk  <= 1'b0;
        edges <= '0;
      end else if (state == SHIFT && tc) begin
        sclk  <= ~sclk;
        edges <= edges + 6'd1;
        if (!sclk) frame <= {frame[14:0], miso};
      end

      if (closing) begin
        if (frame_ok) begin
          temp_valor    <= temp_new;
          muestra_lista <= 1'b1;
          if (qualifies) begin
            if (conf_cnt == 4'(N_CONFIRM - 1)) begin
              adress   <= ~adress;
              conf_cnt <= '0;
            end else begin
              conf_cnt <= conf_cnt + 4'd1;
            end
          end else begin
            conf_cnt <= '0;
          end
        end else begin
          error_trama <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_temp_clasificador.sv
module tb_sensor_temp_clasificador;

  localparam int CLK_DIV   = 4;
  localparam int GAP       = 50;
  localparam int T_LOW     = 20;
  localparam int HYST      = 3;
  localparam int N_CONFIRM = 3;
  localparam int LOW_CLKS  = 33 * CLK_DIV;
  localparam int PERIOD    = 33 * CLK_DIV + 1 + GAP;

  logic       clk;
  logic       reset_n;
  logic       habilitar;
  logic       miso;
  logic       cs_n;
  logic       sclk;
  logic       adress;
  logic [7:0] temp_valor;
  logic       muestra_lista;
  logic       error_trama;

  sensor_temp_clasificador #(
    .CLK_DIV(CLK_DIV), .GAP(GAP), .T_LOW(8'(T_LOW)), .HYST(8'(HYST)),
    .N_CONFIRM(N_CONFIRM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .habilitar(habilitar), .miso(miso),
    .cs_n(cs_n), .sclk(sclk), .adress(adress), .temp_valor(temp_valor),
    .muestra_lista(muestra_lista), .error_trama(error_trama)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_adr, m_cnt, m_temp, m_err;
  int last_pulse = -1;
  int drop_at = 0;

  logic [15:0] adc_word;

  // ADC model: word latched at cs_n falling, MSB first, next bit after each sclk fall.
  initial begin
    logic [15:0] w;
    miso = 1'b0;
    adc_word = 16'h0;
    forever begin
      @(negedge cs_n);
      w = adc_word;
      for (int b = 15; b >= 0; b--) begin
        miso = w[b];
        @(negedge sclk or posedge cs_n);
        if (cs_n) break;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_adr = 0; m_cnt = 0; m_temp = 0; m_err = 0; last_pulse = -1;
  endtask

  task automatic do_frame(input logic [15:0] w, input string tag, input bit chk_period);
    bit ok;
    bit valid;
    int lows, rises, t;
    logic prev_sclk;
    adc_word = w;
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (!cs_n) begin ok = 1; break; end
    end
    check({tag, " cs_low_timeout"}, 32'(ok), 32'd1);
    lows = 1; rises = 0; prev_sclk = sclk; ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (sclk && !prev_sclk) begin
        rises++;
        if (rises == drop_at) habilitar = 1'b0;
      end
      prev_sclk = sclk;
      if (cs_n) begin ok = 1; break; end
      lows++;
    end
    check({tag, " cs_high_timeout"}, 32'(ok), 32'd1);
    // Model the frame from the rules.
    valid = (w[15:12] == 4'h0) && (w[3:0] == 4'h0);
    if (valid) begin
      t = int'(w[11:4]);
      m_temp = t;
      if ((m_adr == 0 && t < T_LOW) || (m_adr == 1 && t >= T_LOW + HYST)) begin
        m_cnt++;
        if (m_cnt == N_CONFIRM) begin m_adr = 1 - m_adr; m_cnt = 0; end
      end else begin
        m_cnt = 0;
      end
    end else begin
      m_err = 1;
    end
    check({tag, " pulse"},  32'(muestra_lista), 32'(valid));
    check({tag, " temp"},   32'(temp_valor), 32'(m_temp));
    check({tag, " adress"}, 32'(adress), 32'(m_adr));
    check({tag, " err"},    32'(error_trama), 32'(m_err));
    check({tag, " sclk_rises"}, 32'(rises), 32'd16);
    check({tag, " cs_low_clks"}, 32'(lows), 32'(LOW_CLKS));
    if (valid) begin
      if (chk_period) check({tag, " period"}, 32'(cyc - last_pulse), 32'(PERIOD));
      last_pulse = cyc;
    end
    @(posedge clk); #1;
    check({tag, " pulse_width"}, 32'(muestra_lista), 32'd0);
  endtask

  function automatic logic [15:0] tw(input int t);
    logic [7:0] b;
    b = 8'(t);
    return {4'h0, b, 4'h0};
  endfunction

  initial begin
    logic [15:0] w;
    int r, cnt_low;
    bit ok;
    reset_n = 1'b0;
    habilitar = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst cs_n", 32'(cs_n), 32'd1);
    check("rst sclk", 32'(sclk), 32'd0);
    check("rst adress", 32'(adress), 32'd0);
    check("rst temp", 32'(temp_valor), 32'd0);
    check("rst pulse", 32'(muestra_lista), 32'd0);
    check("rst err", 32'(error_trama), 32'd0);
    reset_n = 1'b1;
    habilitar = 1'b1;

    do_frame(tw(25), "t25a", 0);
    do_frame(tw(25), "t25b", 1);
    do_frame(tw(25), "t25c", 1);
    // 19,19,25,19 must not trigger; then 19,19 completes three in a row.
    do_frame(tw(19), "s19a", 1);
    do_frame(tw(19), "s19b", 1);
    do_frame(tw(25), "s25",  1);
    do_frame(tw(19), "s19c", 1);
    do_frame(tw(19), "s19d", 1);
    do_frame(tw(19), "s19e", 1);
    check("adress_rose", 32'(adress), 32'd1);
    do_frame(tw(22), "x22a", 1);
    do_frame(tw(22), "x22b", 1);
    do_frame(tw(22), "x22c", 1);
    do_frame(tw(23), "x23a", 1);
    do_frame(tw(23), "x23b", 1);
    do_frame(tw(23), "x23c", 1);
    check("adress_fell", 32'(adress), 32'd0);
    do_frame(tw(20), "e20", 1);
    do_frame(tw(0),  "e0",  1);
    do_frame(16'h2190, "bad_hi", 0);
    do_frame(tw(0),  "e0b", 0);
    do_frame(16'h0193, "bad_lo", 0);
    do_frame(tw(255), "e255", 0);

    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        w = 16'($urandom);
        if (w[15:12] == 4'h0 && w[3:0] == 4'h0) w[15] = 1'b1;
      end else begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      w = tw(0);
        else if (r == 1) w = tw(255);
        else             w = tw(int'($urandom_range(14, 28)));
      end
      do_frame(w, "rand", 0);
    end

    for (int i = 0; i < 4 && m_adr == 0; i++) do_frame(tw(5), "force_low", 0);

    // habilitar dropped at the 5th sclk rise: frame completes, then idle.
    drop_at = 5;
    do_frame(tw(22), "drop", 0);
    drop_at = 0;
    cnt_low = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (!cs_n || sclk) cnt_low++;
    end
    check("idle_no_frame", 32'(cnt_low), 32'd0);

    // Reset pulse mid-SHIFT.
    habilitar = 1'b1;
    adc_word = tw(7);
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (!cs_n) begin ok = 1; break; end
    end
    check("rst2 start", 32'(ok), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rst2 cs_n", 32'(cs_n), 32'd1);
    check("rst2 sclk", 32'(sclk), 32'd0);
    check("rst2 adress", 32'(adress), 32'd0);
    check("rst2 temp", 32'(temp_valor), 32'd0);
    check("rst2 err", 32'(error_trama), 32'd0);
    check("rst2 pulse", 32'(muestra_lista), 32'd0);
    model_reset();
    do_frame(tw(19), "fresh", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
